mat_vect_mult_axis: RTL and testbench

Parametrised successor of the single-row matrix-vector multiplier. It loads an N_COLS-element vector over its own AXI-Stream slave, then streams an N_ROWS x N_COLS matrix in row-major order and emits one dot-product per row on an AXI-Stream master. Adds full tready/tvalid backpressure, a signed mode, vector reuse across matrices, and row-length error detection. It sits between the matrix DMA stream and the result stream in the accelerator datapath.

---
 rtl/mat_vect_pkg.sv | 18 +
 rtl/mat_vect_mac.sv | 30 +++
 rtl/mat_vect_mult_axis.sv | 171 +++++++++++++++++
 tb/tb_mat_vect_mult_axis.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_vect_pkg.sv
// Shared types and width helpers for the streaming matrix-vector multiplier.
package mat_vect_pkg;

    typedef enum logic {
        VLOAD = 1'b0,
        RUN   = 1'b1
    } state_t;

    // The accumulator is wide enough that N_COLS full-scale products can never overflow.
    function automatic int acc_width(input int dw, input int ncols);
        return 2 * dw + $clog2(ncols);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mat_vect_mac.sv
// Combinational multiply-accumulate: width-extended product, then either added to
// the running sum or used on its own to start a new row.
module mat_vect_mac #(
    parameter int DW     = 8,
    parameter int ACCW   = 18,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    input  logic [ACCW-1:0] i_acc,
    input  logic            i_restart,
    output logic [ACCW-1:0] o_sum
);

    logic [ACCW-1:0] w_a_ext;
    logic [ACCW-1:0] w_b_ext;
    logic [ACCW-1:0] w_prod;
    logic            w_a_fill;
    logic            w_b_fill;

    assign w_a_fill = SIGNED ? i_a[DW-1] : 1'b0;
    assign w_b_fill = SIGNED ? i_b[DW-1] : 1'b0;
    assign w_a_ext  = {{(ACCW - DW){w_a_fill}}, i_a};
    assign w_b_ext  = {{(ACCW - DW){w_b_fill}}, i_b};

    // The low ACCW bits of a modular product of extended operands are correct in both modes.
    assign w_prod = w_a_ext * w_b_ext;
    assign o_sum  = i_restart ? w_prod : i_acc + w_prod;

endmodule

// File: rtl/mat_vect_mult_axis.sv
// AXI-Stream matrix-vector multiplier: loads a vector, then emits one dot-product
// per streamed matrix row, with backpressure, vector reuse and row-length checking.
module mat_vect_mult_axis
    import mat_vect_pkg::*;
#(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACCW   = acc_width(DW, N_COLS)
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [DW-1:0]   v_axis_tdata,
    input  logic            v_axis_tvalid,
    input  logic            v_axis_tlast,
    output logic            v_axis_tready,
    input  logic [DW-1:0]   s_axis_tdata,
    input  logic            s_axis_tvalid,
    input  logic            s_axis_tlast,
    output logic            s_axis_tready,
    output logic [ACCW-1:0] m_axis_tdata,
    output logic            m_axis_tvalid,
    output logic            m_axis_tlast,
    input  logic            m_axis_tready,
    input  logic            reuse_vect,
    input  logic            err_clr,
    output logic            err_len
);

    localparam int COL_W = idx_width(N_COLS);
    localparam int ROW_W = idx_width(N_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [COL_W-1:0] r_vidx;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [DW-1:0]   r_vec [N_COLS];
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] r_m_tdata;
    logic            r_m_tvalid;
    logic            r_m_tlast;
    logic            r_err_len;

    logic [ACCW-1:0] w_sum;
    logic            w_v_hs;
    logic            w_s_hs;
    logic            w_m_hs;
    logic            w_vidx_last;
    logic            w_col_last;
    logic            w_row_end;
    logic            w_mat_end;
    logic            w_len_err;

    assign w_vidx_last = (r_vidx == COL_LAST);
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_end   = w_col_last || s_axis_tlast;
    assign w_mat_end   = w_row_end && (r_row == ROW_LAST);

    // Only a row-ending beat can be blocked, and only by an output beat that cannot drain.
    assign v_axis_tready = (r_state == VLOAD) && !areset;
    assign s_axis_tready = (r_state == RUN) && (!w_row_end || !r_m_tvalid || m_axis_tready);

    assign w_v_hs = v_axis_tvalid && v_axis_tready;
    assign w_s_hs = s_axis_tvalid && s_axis_tready;
    assign w_m_hs = r_m_tvalid && m_axis_tready;

    assign w_len_err = (w_v_hs && (v_axis_tlast != w_vidx_last))
                    || (w_s_hs && (s_axis_tlast != w_col_last));

    mat_vect_mac #(
        .DW     (DW),
        .ACCW   (ACCW),
        .SIGNED (SIGNED)
    ) u_mac (
        .i_a       (s_axis_tdata),
        .i_b       (r_vec[r_col]),
        .i_acc     (r_acc),
        .i_restart (r_col == '0),
        .o_sum     (w_sum)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= VLOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            VLOAD: begin
                if (w_v_hs && w_vidx_last) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_s_hs && w_mat_end && !reuse_vect) begin
                    w_state_next = VLOAD;
                end
            end
            default: w_state_next = VLOAD;
        endcase
    end

    // NOTE: the vector file is reset so that a reset mid-load never leaves stale elements behind.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_vidx <= '0;
            for (int i = 0; i < N_COLS; i++) begin
                r_vec[i] <= '0;
            end
        end else if (w_v_hs) begin
            r_vec[r_vidx] <= v_axis_tdata;
            r_vidx        <= w_vidx_last ? '0 : r_vidx + COL_W'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_col <= '0;
            r_row <= '0;
            r_acc <= '0;
        end else if (w_s_hs) begin
            r_acc <= w_sum;
            if (w_row_end) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // A row end accepted on the same edge as a drain reloads the register back-to-back.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_s_hs && w_row_end) begin
            r_m_tdata  <= w_sum;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (r_row == ROW_LAST);
        end else if (w_m_hs) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_err_len <= 1'b0;
        end else if (w_len_err) begin
            r_err_len <= 1'b1;
        end else if (err_clr) begin
            r_err_len <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign err_len       = r_err_len;

endmodule

// File: tb/tb_mat_vect_mult_axis.sv
// Directed bench: an unsigned and a signed instance share every input; the
// unsigned one is checked throughout, the signed one in the signed-mode sequence.
module tb_mat_vect_mult_axis;

    localparam int ACCW = 18;

    logic            aclk;
    logic            areset;
    logic [7:0]      v_tdata;
    logic            v_tvalid;
    logic            v_tlast;
    logic [7:0]      s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            m_tready;
    logic            reuse_vect;
    logic            err_clr;

    logic            u_v_tready, u_s_tready, u_m_tvalid, u_m_tlast, u_err_len;
    logic [ACCW-1:0] u_m_tdata;
    logic            g_v_tready, g_s_tready, g_m_tvalid, g_m_tlast, g_err_len;
    logic [ACCW-1:0] g_m_tdata;

    int n_tests = 0;
    int n_fail  = 0;

    mat_vect_mult_axis #(.N_ROWS(2), .N_COLS(3), .DW(8), .SIGNED(1'b0)) u_dut (
        .aclk(aclk), .areset(areset),
        .v_axis_tdata(v_tdata), .v_axis_tvalid(v_tvalid), .v_axis_tlast(v_tlast),
        .v_axis_tready(u_v_tready),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(u_s_tready),
        .m_axis_tdata(u_m_tdata), .m_axis_tvalid(u_m_tvalid), .m_axis_tlast(u_m_tlast),
        .m_axis_tready(m_tready),
        .reuse_vect(reuse_vect), .err_clr(err_clr), .err_len(u_err_len)
    );

    mat_vect_mult_axis #(.N_ROWS(2), .N_COLS(3), .DW(8), .SIGNED(1'b1)) g_dut (
        .aclk(aclk), .areset(areset),
        .v_axis_tdata(v_tdata), .v_axis_tvalid(v_tvalid), .v_axis_tlast(v_tlast),
        .v_axis_tready(g_v_tready),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(g_s_tready),
        .m_axis_tdata(g_m_tdata), .m_axis_tvalid(g_m_tvalid), .m_axis_tlast(g_m_tlast),
        .m_axis_tready(m_tready),
        .reuse_vect(reuse_vect), .err_clr(err_clr), .err_len(g_err_len)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0][7:0]      vec;
        logic [1:0][2:0][7:0] mat;
        logic [1:0][31:0]     res;
    } vect_t;

    vect_t tbl [4];

    function automatic vect_t mk(input logic [7:0] v0, v1, v2,
                                 input logic [7:0] a0, a1, a2, b0, b1, b2,
                                 input logic [31:0] r0, r1);
        vect_t t;
        t.vec = {v2, v1, v0};
        t.mat = {{b2, b1, b0}, {a2, a1, a0}};
        t.res = {r1, r0};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_vbeat(input logic [7:0] d, input logic last);
        int n = 0;
        v_tdata = d; v_tvalid = 1'b1; v_tlast = last;
        @(negedge aclk);
        while (!u_v_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("v_beat_accept", 32'(u_v_tready), 32'd1);
        @(posedge aclk); #1;
        v_tvalid = 1'b0; v_tlast = 1'b0;
    endtask

    task automatic load_vec(input logic [7:0] v0, v1, v2, input logic [2:0] last_mask);
        send_vbeat(v0, last_mask[0]);
        send_vbeat(v1, last_mask[1]);
        send_vbeat(v2, last_mask[2]);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
        @(negedge aclk);
        while (!u_s_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("s_beat_accept", 32'(u_s_tready), 32'd1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] d0, d1, d2);
        send_beat(d0, 1'b0);
        send_beat(d1, 1'b0);
        send_beat(d2, 1'b1);
    endtask

    task automatic check_out(input string name, input logic [31:0] data, input logic last);
        check({name, "_tvalid"}, 32'(u_m_tvalid), 32'd1);
        check({name, "_tdata"},  32'(u_m_tdata),  data);
        check({name, "_tlast"},  32'(u_m_tlast),  32'(last));
    endtask

    initial begin
        areset = 1'b1;
        v_tdata = '0; v_tvalid = 1'b0; v_tlast = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; reuse_vect = 1'b0; err_clr = 1'b0;

        tbl[0] = mk(8'd1, 8'd2, 8'd3,       8'd1, 8'd1, 8'd1,       8'd2, 8'd0, 8'd1,   32'd6,      32'd5);
        tbl[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 32'd195075, 32'd195075);
        tbl[2] = mk(8'd10, 8'd0, 8'd7,      8'd3, 8'd9, 8'd2,       8'd0, 8'd0, 8'd0,   32'd44,     32'd0);
        tbl[3] = mk(8'd200, 8'd1, 8'd2,     8'd1, 8'd100, 8'd50,    8'd255, 8'd0, 8'd0, 32'd400,    32'd51000);

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_v_tready", 32'(u_v_tready), 32'd0);
        check("rst_s_tready", 32'(u_s_tready), 32'd0);
        check("rst_m_tvalid", 32'(u_m_tvalid), 32'd0);
        check("rst_m_tdata",  32'(u_m_tdata),  32'd0);
        check("rst_m_tlast",  32'(u_m_tlast),  32'd0);
        check("rst_err_len",  32'(u_err_len),  32'd0);
        areset = 1'b0;
        #1;
        check("post_rst_v_tready", 32'(u_v_tready), 32'd1);

        // Table-driven matrices, m_tready held high
        for (int i = 0; i < 4; i++) begin
            load_vec(tbl[i].vec[0], tbl[i].vec[1], tbl[i].vec[2], 3'b100);
            check("tbl_s_tready_run", 32'(u_s_tready), 32'd1);
            send_row(tbl[i].mat[0][0], tbl[i].mat[0][1], tbl[i].mat[0][2]);
            check_out("tbl_row0", tbl[i].res[0], 1'b0);
            send_row(tbl[i].mat[1][0], tbl[i].mat[1][1], tbl[i].mat[1][2]);
            check_out("tbl_row1", tbl[i].res[1], 1'b1);
            check("tbl_v_tready_back", 32'(u_v_tready), 32'd1);
            check("tbl_err_len", 32'(u_err_len), 32'd0);
        end

        // Backpressure: first result held while the second row's final beat stalls
        @(posedge aclk); #1;
        m_tready = 1'b0;
        load_vec(8'd1, 8'd2, 8'd3, 3'b100);
        send_row(8'd1, 8'd1, 8'd1);
        check_out("bp_row0", 32'd6, 1'b0);
        fork
            begin
                repeat (5) @(posedge aclk);
                #1 m_tready = 1'b1;
            end
        join_none
        send_beat(8'd2, 1'b0);
        send_beat(8'd0, 1'b0);
        s_tdata = 8'd1; s_tvalid = 1'b1; s_tlast = 1'b1;
        @(negedge aclk);
        check("bp_stall_s_tready", 32'(u_s_tready), 32'd0);
        check("bp_hold_tdata", 32'(u_m_tdata), 32'd6);
        check("bp_hold_tlast", 32'(u_m_tlast), 32'd0);
        send_beat(8'd1, 1'b1);
        check_out("bp_row1", 32'd5, 1'b1);

        // Row-length error: tlast on the second beat
        load_vec(8'd1, 8'd2, 8'd3, 3'b100);
        send_beat(8'd4, 1'b0);
        send_beat(8'd5, 1'b1);
        check_out("err_short_row", 32'd14, 1'b0);
        check("err_len_set", 32'(u_err_len), 32'd1);
        send_row(8'd1, 8'd1, 8'd1);
        check_out("err_next_row", 32'd6, 1'b1);
        check("err_len_sticky", 32'(u_err_len), 32'd1);
        err_clr = 1'b1;
        @(posedge aclk); #1;
        err_clr = 1'b0;
        check("err_len_cleared", 32'(u_err_len), 32'd0);

        // Vector-length error: tlast on the first beat, missing on the last
        load_vec(8'd1, 8'd1, 8'd1, 3'b001);
        check("vlen_err_set", 32'(u_err_len), 32'd1);
        check("vlen_load_done", 32'(u_s_tready), 32'd1);
        send_row(8'd0, 8'd0, 8'd0);
        send_row(8'd0, 8'd1, 8'd0);
        check_out("vlen_row1", 32'd1, 1'b1);
        err_clr = 1'b1;
        @(posedge aclk); #1;
        err_clr = 1'b0;
        check("vlen_err_cleared", 32'(u_err_len), 32'd0);

        // Vector reuse across two matrices
        reuse_vect = 1'b1;
        load_vec(8'd1, 8'd2, 8'd3, 3'b100);
        send_row(8'd1, 8'd1, 8'd1);
        send_row(8'd2, 8'd0, 8'd1);
        check_out("reuse_m0_row1", 32'd5, 1'b1);
        check("reuse_v_tready", 32'(u_v_tready), 32'd0);
        check("reuse_s_tready", 32'(u_s_tready), 32'd1);
        send_row(8'd3, 8'd3, 8'd3);
        check_out("reuse_m1_row0", 32'd18, 1'b0);
        reuse_vect = 1'b0;
        send_row(8'd0, 8'd1, 8'd0);
        check_out("reuse_m1_row1", 32'd2, 1'b1);
        check("reuse_end_v_tready", 32'(u_v_tready), 32'd1);

        // Reset in the middle of a row discards partial work
        load_vec(8'd1, 8'd2, 8'd3, 3'b100);
        send_beat(8'd5, 1'b0);
        send_beat(8'd5, 1'b0);
        areset = 1'b1;
        #1;
        check("mid_rst_m_tdata",  32'(u_m_tdata),  32'd0);
        check("mid_rst_m_tvalid", 32'(u_m_tvalid), 32'd0);
        check("mid_rst_m_tlast",  32'(u_m_tlast),  32'd0);
        check("mid_rst_s_tready", 32'(u_s_tready), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        check("mid_rst_vload", 32'(u_v_tready), 32'd1);
        load_vec(8'd2, 8'd2, 8'd2, 3'b100);
        send_row(8'd1, 8'd1, 8'd1);
        check_out("mid_rst_row0", 32'd6, 1'b0);
        send_row(8'd0, 8'd0, 8'd0);
        check_out("mid_rst_row1", 32'd0, 1'b1);

        // Signed mode on the second instance
        load_vec(8'hFF, 8'h02, 8'h7F, 3'b100);
        send_row(8'h80, 8'h80, 8'h80);
        check("signed_row0_tdata", 32'(g_m_tdata), 32'h3C000);
        check("signed_row0_tvalid", 32'(g_m_tvalid), 32'd1);
        send_row(8'h00, 8'h00, 8'h01);
        check("signed_row1_tdata", 32'(g_m_tdata), 32'd127);
        check("signed_row1_tlast", 32'(g_m_tlast), 32'd1);
        check("signed_v_tready", 32'(g_v_tready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
